// File: rtl/conv1d_sequencer.sv
// Control FSM for one 1D-convolution frame on a shared single-MAC datapath.
// Streams K weights then N samples into external memories, then issues K MAC beats per output position.
module conv1d_sequencer #(
   parameter int K           = 3,
   parameter int N           = 5,
   parameter int MAC_LATENCY = 4,
   parameter int AW_X        = $clog2(N),
   parameter int AW_W        = $clog2(K)
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_input_valid,
   output logic            o_input_ready,
   input  logic            i_output_ready,
   output logic            o_output_valid,
   output logic [AW_X-1:0] o_addr_x,
   output logic            o_wr_en_x,
   output logic [AW_W-1:0] o_addr_w,
   output logic            o_wr_en_w,
   output logic            o_en_mac,
   output logic            o_clear_acc,
   output logic            o_frame_done
);

   localparam int DW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

   localparam logic [AW_W-1:0] W_LAST     = AW_W'(K - 1);
   localparam logic [AW_X-1:0] X_LAST     = AW_X'(N - 1);
   localparam logic [AW_X-1:0] POS_LAST   = AW_X'(N - K);
   localparam logic [DW-1:0]   DRAIN_LAST = DW'(MAC_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_W,
      S_LOAD_X,
      S_ISSUE,
      S_DRAIN,
      S_OUT
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [AW_W-1:0] r_wcnt;
   logic [AW_W-1:0] w_wcnt_nxt;
   logic [AW_X-1:0] r_xcnt;
   logic [AW_X-1:0] w_xcnt_nxt;
   logic [AW_X-1:0] r_pos;
   logic [AW_X-1:0] w_pos_nxt;
   logic [AW_W-1:0] r_tap;
   logic [AW_W-1:0] w_tap_nxt;
   logic [DW-1:0]   r_dcnt;
   logic [DW-1:0]   w_dcnt_nxt;
   logic [AW_X-1:0] w_issue_addr_x;

   // pos+tap never exceeds N-1, so the sum fits AW_X without wrap.
   assign w_issue_addr_x = r_pos + AW_X'(r_tap);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_wcnt  <= '0;
         r_xcnt  <= '0;
         r_pos   <= '0;
         r_tap   <= '0;
         r_dcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_wcnt  <= w_wcnt_nxt;
         r_xcnt  <= w_xcnt_nxt;
         r_pos   <= w_pos_nxt;
         r_tap   <= w_tap_nxt;
         r_dcnt  <= w_dcnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_wcnt_nxt     = r_wcnt;
      w_xcnt_nxt     = r_xcnt;
      w_pos_nxt      = r_pos;
      w_tap_nxt      = r_tap;
      w_dcnt_nxt     = r_dcnt;
      o_input_ready  = 1'b0;
      o_output_valid = 1'b0;
      o_addr_x       = '0;
      o_addr_w       = '0;
      o_wr_en_x      = 1'b0;
      o_wr_en_w      = 1'b0;
      o_en_mac       = 1'b0;
      o_clear_acc    = 1'b0;
      o_frame_done   = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_state_nxt = S_LOAD_W;
         end

         S_LOAD_W: begin
            o_input_ready = 1'b1;
            o_addr_w      = r_wcnt;
            if (i_input_valid) begin
               o_wr_en_w = 1'b1;
               if (r_wcnt == W_LAST) begin
                  w_wcnt_nxt  = '0;
                  w_state_nxt = S_LOAD_X;
               end else begin
                  w_wcnt_nxt = r_wcnt + 1'b1;
               end
            end
         end

         S_LOAD_X: begin
            o_input_ready = 1'b1;
            o_addr_x      = r_xcnt;
            if (i_input_valid) begin
               o_wr_en_x = 1'b1;
               if (r_xcnt == X_LAST) begin
                  w_xcnt_nxt  = '0;
                  w_pos_nxt   = '0;
                  w_tap_nxt   = '0;
                  w_state_nxt = S_ISSUE;
               end else begin
                  w_xcnt_nxt = r_xcnt + 1'b1;
               end
            end
         end

         // tap is left at K-1 on exit so DRAIN/OUT keep showing the last issued addresses.
         S_ISSUE: begin
            o_en_mac = 1'b1;
            o_addr_x = w_issue_addr_x;
            o_addr_w = r_tap;
            if (r_tap == W_LAST) begin
               w_dcnt_nxt  = '0;
               w_state_nxt = S_DRAIN;
            end else begin
               w_tap_nxt = r_tap + 1'b1;
            end
         end

         S_DRAIN: begin
            o_addr_x = w_issue_addr_x;
            o_addr_w = r_tap;
            if (r_dcnt == DRAIN_LAST) begin
               w_state_nxt = S_OUT;
            end else begin
               w_dcnt_nxt = r_dcnt + 1'b1;
            end
         end

         S_OUT: begin
            o_output_valid = 1'b1;
            o_addr_x       = w_issue_addr_x;
            o_addr_w       = r_tap;
            if (i_output_ready) begin
               o_clear_acc = 1'b1;
               w_tap_nxt   = '0;
               if (r_pos != POS_LAST) begin
                  w_pos_nxt   = r_pos + 1'b1;
                  w_state_nxt = S_ISSUE;
               end else begin
                  o_frame_done = 1'b1;
                  w_pos_nxt    = '0;
                  w_state_nxt  = S_LOAD_W;
               end
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_conv1d_sequencer.sv
// Bench for conv1d_sequencer: behavioural 1-cycle-read memories and MAC around the sequencer,
// with a result scoreboard and per-cycle protocol monitor.
module tb_conv1d_sequencer;

   localparam int K      = 3;
   localparam int N      = 5;
   localparam int L      = 4;
   localparam int AW_X   = $clog2(N);
   localparam int AW_W   = $clog2(K);
   localparam int NOUT   = N - K + 1;
   localparam int PERIOD = K + L + 1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic            out_ready;
   logic            out_valid;
   logic [AW_X-1:0] addr_x;
   logic            wr_en_x;
   logic [AW_W-1:0] addr_w;
   logic            wr_en_w;
   logic            en_mac;
   logic            clear_acc;
   logic            frame_done;
   logic signed [15:0] in_data;

   always #5 clk = ~clk;

   conv1d_sequencer #(
      .K(K), .N(N), .MAC_LATENCY(L), .AW_X(AW_X), .AW_W(AW_W)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_input_valid  (in_valid),
      .o_input_ready  (in_ready),
      .i_output_ready (out_ready),
      .o_output_valid (out_valid),
      .o_addr_x       (addr_x),
      .o_wr_en_x      (wr_en_x),
      .o_addr_w       (addr_w),
      .o_wr_en_w      (wr_en_w),
      .o_en_mac       (en_mac),
      .o_clear_acc    (clear_acc),
      .o_frame_done   (frame_done)
   );

   // Behavioural memories (1-cycle read) and MAC.
   logic signed [15:0] wmem [K];
   logic signed [15:0] xmem [N];
   logic signed [15:0] rd_w;
   logic signed [15:0] rd_x;
   logic               en_d1;
   logic signed [31:0] acc;

   always @(posedge clk) begin
      if (wr_en_w) wmem[addr_w] <= in_data;
      if (wr_en_x) xmem[addr_x] <= in_data;
      rd_w <= wmem[addr_w];
      rd_x <= xmem[addr_x];
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_d1 <= 1'b0;
         acc   <= '0;
      end else begin
         en_d1 <= en_mac;
         if (clear_acc) acc <= '0;
         else if (en_d1) acc <= acc + 32'(rd_w) * 32'(rd_x);
      end
   end

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int fw[K];
   int fx[N];
   int cyc = 0;

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Protocol monitor and scoreboard consumer.
   int              out_idx = 0;
   int              out_total = 0;
   int              en_cnt = 0;
   int              exp_wa = 0;
   int              exp_xa = 0;
   int              last_x_cyc = 0;
   int              prev_hs_cyc = 0;
   bit              stalled = 0;
   bit              fd_prev = 0;
   bit              ov_prev = 0;
   bit              hs;
   logic [AW_X-1:0] ax_prev;
   logic [AW_W-1:0] aw_prev;

   always @(negedge clk) begin
      if (!rst_n) begin
         out_idx = 0; en_cnt = 0; exp_wa = 0; exp_xa = 0;
         stalled = 0; fd_prev = 0; ov_prev = 0;
      end else begin
         hs = out_valid && out_ready;
         check("strobe_excl", int'(int'(wr_en_x) + int'(wr_en_w) + int'(en_mac) > 1), 0);
         if (out_valid) check("strobes_in_out", {wr_en_x, wr_en_w, en_mac}, 0);
         check("clear_acc", clear_acc, hs);
         check("frame_done", frame_done, hs && (out_idx == NOUT - 1));
         if (fd_prev) check("ready_after_done", in_ready, 1);
         if (wr_en_w) begin
            check("w_beat", in_valid && in_ready, 1);
            check("addr_w_load", addr_w, exp_wa);
            exp_wa++;
         end
         if (wr_en_x) begin
            check("x_beat", in_valid && in_ready, 1);
            check("addr_x_load", addr_x, exp_xa);
            exp_xa++;
            last_x_cyc = cyc;
         end
         if (en_mac) en_cnt++;
         if (out_valid && ov_prev) begin
            check("addr_x_frozen", addr_x, ax_prev);
            check("addr_w_frozen", addr_w, aw_prev);
         end
         if (out_valid && !out_ready) stalled = 1;
         if (hs) begin
            if (exp_q.size() == 0) check("sb_nonempty", exp_q.size(), 1);
            else check("result", acc, exp_q.pop_front());
            if (out_idx == 0) check("first_latency", cyc - last_x_cyc, PERIOD);
            else if (!stalled) check("spacing", cyc - prev_hs_cyc, PERIOD);
            prev_hs_cyc = cyc;
            stalled = 0;
            out_total++;
            if (out_idx == NOUT - 1) begin
               check("en_mac_count", en_cnt, K * NOUT);
               check("w_loaded", exp_wa, K);
               check("x_loaded", exp_xa, N);
               out_idx = 0; en_cnt = 0; exp_wa = 0; exp_xa = 0;
            end else begin
               out_idx++;
            end
         end
         fd_prev = frame_done;
         ov_prev = out_valid;
         ax_prev = addr_x;
         aw_prev = addr_w;
      end
   end

   task automatic push_expected();
      for (int p = 0; p < NOUT; p++) begin
         int s = 0;
         for (int t = 0; t < K; t++) s += fw[t] * fx[p + t];
         exp_q.push_back(s);
      end
   endtask

   task automatic send_word(input int v, input bit gap);
      bit taken = 0;
      int t = 0;
      in_valid = 1'b1;
      in_data  = 16'(v);
      do begin
         @(negedge clk);
         taken = in_ready;
         @(posedge clk); #1;
         t++;
      end while (!taken && t < 64);
      if (!taken) check("input_timeout", taken, 1);
      in_valid = 1'b0;
      if (gap) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic load_frame(input bit gap);
      push_expected();
      for (int k = 0; k < K; k++) send_word(fw[k], gap);
      for (int n = 0; n < N; n++) send_word(fx[n], gap);
   endtask

   task automatic wait_total(input int target);
      int t = 0;
      while (out_total < target && t < 300) begin
         @(posedge clk);
         t++;
      end
      check("wait_outputs", out_total >= target, 1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_wr_en_x"}, wr_en_x, 0);
      check({tag, "_wr_en_w"}, wr_en_w, 0);
      check({tag, "_en_mac"}, en_mac, 0);
      check({tag, "_clear_acc"}, clear_acc, 0);
      check({tag, "_frame_done"}, frame_done, 0);
      check({tag, "_addr_x"}, addr_x, 0);
      check({tag, "_addr_w"}, addr_w, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      #2;
      check_all_zero("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Basic frame; junk words held valid outside load states must be ignored.
      fw = '{1, 2, 3};
      fx = '{1, 2, 3, 4, 5};
      base = out_total;
      load_frame(0);
      in_valid = 1'b1;
      in_data  = 16'sd99;
      wait_total(base + 1);
      #1 in_valid = 1'b0;
      wait_total(base + NOUT);
      check("sb_drained_1", exp_q.size(), 0);

      // Input valid toggling 1010...
      base = out_total;
      load_frame(1);
      wait_total(base + NOUT);

      // Downstream stall on the second result.
      base = out_total;
      load_frame(0);
      wait_total(base + 1);
      #1 out_ready = 1'b0;
      for (int t = 0; t < 100; t++) begin
         @(posedge clk); #1;
         if (out_valid) break;
      end
      for (int i = 0; i < 7; i++) begin
         check("stall_valid", out_valid, 1);
         check("stall_no_mac", en_mac, 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      wait_total(base + NOUT);

      // Signed data with ready tied high: spacing and en_mac count checked by the monitor.
      fw = '{-2, 5, 7};
      fx = '{3, -1, 0, 8, 2};
      base = out_total;
      load_frame(0);
      wait_total(base + NOUT);

      // Reset during ISSUE of pos=1, then a fresh frame.
      fw = '{1, 2, 3};
      fx = '{1, 2, 3, 4, 5};
      base = out_total;
      load_frame(0);
      wait_total(base + 1);
      #1;
      @(posedge clk); #1;
      check("pre_reset_en_mac", en_mac, 1);
      check("pre_reset_addr_x", addr_x, 2);
      check("pre_reset_addr_w", addr_w, 1);
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      fw = '{1, 1, 1};
      fx = '{2, 3, 4, 5, 6};
      base = out_total;
      load_frame(0);
      wait_total(base + NOUT);

      // Two frames back to back.
      fw = '{4, -3, 2};
      fx = '{9, 1, -4, 1, 5};
      base = out_total;
      load_frame(0);
      fw = '{1, 2, 3};
      fx = '{1, 2, 3, 4, 5};
      load_frame(0);
      wait_total(base + 2 * NOUT);
      check("sb_drained_end", exp_q.size(), 0);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
